// File: rtl/tiny_nn_pkg.sv
// rtl/tiny_nn_pkg.sv - shared constants, enums and saturation helper for tiny_nn
package tiny_nn_pkg;

  localparam int ACC_W  = 24;
  localparam int OPND_W = 8;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_START = 8'h01,
    OP_SHIFT = 8'h02,
    OP_RELU  = 8'h03
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUTPUT
  } state_e;

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return 8'h7F;
    end else if (v < SAT_MIN) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/tiny_nn_mac.sv
// rtl/tiny_nn_mac.sv - signed 8x8 multiplier feeding a clearable accumulator
module tiny_nn_mac
  import tiny_nn_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [OPND_W-1:0] i_w,
  input  logic signed [OPND_W-1:0] i_x,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*OPND_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_w * i_x;
  assign o_acc  = r_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/tiny_nn_top.sv
// rtl/tiny_nn_top.sv - single-neuron engine: command decode, MAC sequencing, shift/ReLU/saturate output
module tiny_nn_top
  import tiny_nn_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] data_i,
  output logic [7:0]  data_o
);

  state_e                  r_state;
  state_e                  w_next;
  logic [7:0]              r_cnt;
  logic [3:0]              r_shift;
  logic                    r_relu;
  logic [7:0]              r_data_o;
  logic                    w_clr;
  logic                    w_en;
  op_e                     w_op;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_post;

  assign w_op   = op_e'(data_i[15:8]);
  assign data_o = r_data_o;

  tiny_nn_mac u_mac (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_w     (data_i[15:8]),
    .i_x     (data_i[7:0]),
    .o_acc   (w_acc)
  );

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op == OP_START) begin
          w_clr  = 1'b1;
          w_next = (data_i[7:0] == 8'd0) ? ST_OUTPUT : ST_MAC;
        end
      end
      ST_MAC: begin
        w_en = 1'b1;
        if (r_cnt == 8'd1) begin
          w_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output stage works on the settled accumulator during the single OUTPUT cycle.
  assign w_shifted = w_acc >>> r_shift;
  assign w_post    = (r_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_shift  <= 4'd0;
      r_relu   <= 1'b0;
      r_data_o <= 8'h00;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          case (w_op)
            OP_START: r_cnt   <= data_i[7:0];
            OP_SHIFT: r_shift <= data_i[3:0];
            OP_RELU:  r_relu  <= data_i[0];
            default:  ;
          endcase
        end
        ST_MAC:    r_cnt    <= r_cnt - 8'd1;
        ST_OUTPUT: r_data_o <= sat8(w_post);
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_nn_top.sv
// tb/tb_tiny_nn_top.sv - directed and randomized neuron checks against an arithmetic reference
module tb_tiny_nn_top;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [7:0]  dout;

  int n_vec = 0;
  int n_err = 0;

  int         m_shift = 0;
  bit         m_relu  = 0;
  logic [7:0] m_out   = 8'h00;

  tiny_nn_top dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (din),
    .data_o (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_act(input longint acc, input int sh, input bit relu);
    longint r;
    r = acc >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) return 8'h7F;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  task automatic step(input logic [15:0] w);
    din = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_vec++;
    assert (dout === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, dout, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] w);
    step(w);
    if (w[15:8] == 8'h02) m_shift = int'(w[3:0]);
    if (w[15:8] == 8'h03) m_relu  = w[0];
    check("cfg_hold", m_out);
  endtask

  task automatic neuron(input string tag, input logic [15:0] pairs[$]);
    longint acc;
    logic [15:0] p;
    acc = 0;
    step({8'h01, 8'(pairs.size())});
    foreach (pairs[i]) begin
      p = pairs[i];
      acc += longint'($signed(p[7:0])) * longint'($signed(p[15:8]));
      step(p);
    end
    check({tag, "_pre"}, m_out);
    step(16'($urandom));
    m_out = ref_act(acc, m_shift, m_relu);
    check(tag, m_out);
  endtask

  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    for (int i = 0; i < edges; i++) step(16'($urandom));
    rst_n = 1'b1;
    m_out = 8'h00;
    m_shift = 0;
    m_relu = 0;
  endtask

  initial begin
    logic [15:0] q[$];
    rst_n = 1'b1;
    din   = 16'h0000;

    do_reset(2);
    check("reset", 8'h00);

    cfg(16'h0200);
    q = {16'h0304, 16'h0205};
    neuron("dot2", q);
    check("dot2_const", 8'h16);

    q = {16'hFE05};
    neuron("neg", q);
    check("neg_const", 8'hF6);
    cfg(16'h0301);
    neuron("neg_relu", q);
    check("neg_relu_const", 8'h00);

    cfg(16'h0300);
    q = {16'h7F7F, 16'h7F7F};
    neuron("sat_pos", q);
    check("sat_pos_const", 8'h7F);
    cfg(16'h0208);
    neuron("shift8", q);
    check("shift8_const", 8'h7E);
    cfg(16'h0200);
    q = {16'h807F};
    neuron("sat_neg", q);
    check("sat_neg_const", 8'h80);

    cfg(16'h0301);
    step(16'h0103);
    step(16'h0506);
    do_reset(1);
    check("abort", 8'h00);
    cfg(16'h0304);
    q = {16'hFD07};
    neuron("after_abort", q);
    check("after_abort_const", 8'hEB);

    q.delete();
    neuron("zero_cnt", q);
    check("zero_cnt_const", 8'h00);
    cfg(16'h0000);
    cfg(16'hABCD);
    check("hold_const", 8'h00);

    for (int t = 0; t < 25; t++) begin
      cfg({8'h02, 4'($urandom), 4'($urandom_range(0, 15))});
      cfg({8'h03, 7'($urandom), 1'($urandom)});
      cfg({8'($urandom_range(4, 255)), 8'($urandom)});
      cfg({8'h00, 8'($urandom)});
      q.delete();
      for (int k = 0; k < int'($urandom_range(0, 9)); k++) q.push_back(16'($urandom));
      neuron("rand", q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
